// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS video sequencer: default 640x480@60 timing,
// sequencer states and the HDMI video guard-band code words.
package tmds_pkg;

    localparam int CNT_W = 12;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } seq_state_e;

    // Guard-band symbols that the encoders substitute while vgb is high
    localparam logic [9:0] GB_CODE_CH0 = 10'b1011001100;
    localparam logic [9:0] GB_CODE_CH1 = 10'b0100110011;
    localparam logic [9:0] GB_CODE_CH2 = 10'b1011001100;

endpackage

// File: rtl/tmds_video_sequencer_pos_counter.sv
// Wrapping position counter (0..TOTAL-1) with a terminal-count flag,
// used once for pixels within a line and once for lines within a frame.
module tmds_pos_counter
    import tmds_pkg::*;
#(
    parameter int TOTAL = 800
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tc_o    = (count_q == LAST);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = tc_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tmds_video_sequencer.sv
// Raster timing sequencer feeding three TMDS encoders (DVI by default).
// Define TMDS_GUARD_BAND_EN to add HDMI video preamble and guard band.
module tmds_video_sequencer
    import tmds_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             pix_req,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             vde,
    output logic [1:0]       cd0,
    output logic [1:0]       cd1,
    output logic [1:0]       cd2,
    output logic             vgb,
    output logic             frame_start,
    output logic             running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEGIN  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_BEGIN  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_IDLE = ~H_POL;
    localparam logic VS_IDLE = ~V_POL;

    seq_state_e       state_q;
    logic [CNT_W-1:0] hCount;
    logic [CNT_W-1:0] vCount;
    logic             hTc;
    logic             vTc;
    logic             atOrigin;
    logic             advance;
    logic             nextActive;
    logic             hsAct;
    logic             vsAct;
    logic [1:0]       cd1_d;
    logic             vgb_d;

    logic             vde_q;
    logic             hsync_q;
    logic             vsync_q;
    logic [1:0]       cd1_q;
    logic             vgb_q;
    logic             frameStart_q;
    logic             running_q;

    // The counters hold the position to be shown on the next cycle; the
    // output registers capture its decode, so pix_req leads vde by one.
    tmds_pos_counter #(.TOTAL(H_TOTAL)) u_hCounter (
        .clk_i   (clk),
        .reset_i (reset),
        .inc_i   (advance),
        .count_o (hCount),
        .tc_o    (hTc)
    );

    tmds_pos_counter #(.TOTAL(V_TOTAL)) u_vCounter (
        .clk_i   (clk),
        .reset_i (reset),
        .inc_i   (advance && hTc),
        .count_o (vCount),
        .tc_o    (vTc)
    );

    assign atOrigin   = (hCount == '0) && (vCount == '0);
    assign nextActive = (hCount < H_ACT_END) && (vCount < V_ACT_END);
    assign hsAct      = (hCount >= HS_BEGIN) && (hCount < HS_END);
    assign vsAct      = (vCount >= VS_BEGIN) && (vCount < VS_END);

    // Once the counters wrap to the origin with enable low, the frame is over.
    assign advance = (state_q == ST_IDLE) ? enable : (enable || !atOrigin);

    assign pix_req = advance && nextActive;
    assign pix_x   = hCount;
    assign pix_y   = vCount;

`ifdef TMDS_GUARD_BAND_EN
    localparam logic [CNT_W-1:0] PRE_BEGIN  = CNT_W'(H_TOTAL - 10);
    localparam logic [CNT_W-1:0] GB_BEGIN   = CNT_W'(H_TOTAL - 2);
    localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);

    logic nextLineActive;

    if (H_BP < 10) begin : g_hbpCheck
        $error("tmds_video_sequencer: H_BP must be at least 10 to hold preamble and guard band");
    end

    assign nextLineActive = vTc || (vCount < V_ACT_LAST);
    assign cd1_d = (nextLineActive && (hCount >= PRE_BEGIN) && (hCount < GB_BEGIN)) ? 2'b01 : 2'b00;
    assign vgb_d = nextLineActive && (hCount >= GB_BEGIN);
`else
    logic unusedVTc;

    assign unusedVTc = vTc;
    assign cd1_d     = 2'b00;
    assign vgb_d     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            vde_q        <= 1'b0;
            hsync_q      <= HS_IDLE;
            vsync_q      <= VS_IDLE;
            cd1_q        <= 2'b00;
            vgb_q        <= 1'b0;
            frameStart_q <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    if (!advance) begin
                        state_q <= ST_IDLE;
                    end else if (enable) begin
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
            endcase

            running_q    <= advance;
            frameStart_q <= advance && atOrigin;
            vde_q        <= advance && nextActive;
            hsync_q      <= (advance && hsAct) ? H_POL : HS_IDLE;
            vsync_q      <= (advance && vsAct) ? V_POL : VS_IDLE;
            cd1_q        <= advance ? cd1_d : 2'b00;
            vgb_q        <= advance && vgb_d;
        end
    end

    assign vde         = vde_q;
    assign cd0         = {vsync_q, hsync_q};
    assign cd1         = cd1_q;
    assign cd2         = 2'b00;
    assign vgb         = vgb_q;
    assign frame_start = frameStart_q;
    assign running     = running_q;

endmodule

// File: tb/tb_tmds_video_sequencer.sv
// Directed self-checking bench for tmds_video_sequencer on a reduced 32x12 raster
// (16+2+4+10 pixels, 6+1+2+3 lines) so whole frames fit in a short run.
module tb_tmds_video_sequencer;

    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HS = 4;
    localparam int HB = 10;
    localparam int VA = 6;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = 32;
    localparam int VT = 12;
    localparam int FRAME = 384;

    // Hand-computed per-frame totals for this raster
    localparam int EXP_VDE_CNT = 96;
    localparam int EXP_HS_CNT  = 48;
    localparam int EXP_VS_CNT  = 64;
`ifdef TMDS_GUARD_BAND_EN
    localparam int EXP_VGB_CNT = 12;
    localparam int EXP_CD1_CNT = 48;
`else
    localparam int EXP_VGB_CNT = 0;
    localparam int EXP_CD1_CNT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        pix_req;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic        vde;
    logic [1:0]  cd0;
    logic [1:0]  cd1;
    logic [1:0]  cd2;
    logic        vgb;
    logic        frame_start;
    logic        running;

    int testsRun = 0;
    int testsFailed = 0;

    int vdeCount;
    int hsCount;
    int vsCount;
    int vgbCount;
    int cd1Count;
    int fsCount;
    int posErr;
    int leadErr;
    int runErr;
    int hsFirst;

    always #5 clk = ~clk;

    tmds_video_sequencer #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .H_POL    (1'b0), .V_POL (1'b0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pix_req     (pix_req),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .vde         (vde),
        .cd0         (cd0),
        .cd1         (cd1),
        .cd2         (cd2),
        .vgb         (vgb),
        .frame_start (frame_start),
        .running     (running)
    );

    task automatic applyStimulus(input logic en, input logic rst);
        enable = en;
        reset  = rst;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Walks one frame from the (0,0) cycle, comparing every cycle against the
    // raster rules and tallying totals; enable drops at the start of dropLine.
    task automatic runFrame(input int dropLine);
        int h, v, nh, nv;
        logic expVde, expHs, expVs, expReq, expVgb, expFs;
        logic [1:0] expCd1;
        vdeCount = 0; hsCount = 0; vsCount = 0; vgbCount = 0; cd1Count = 0;
        fsCount = 0; posErr = 0; leadErr = 0; runErr = 0; hsFirst = -1;
        for (int c = 0; c < FRAME; c++) begin
            h = c % HT;
            v = c / HT;
            if (h == 0 && v == dropLine) applyStimulus(1'b0, 1'b0);
            nh = (h == HT - 1) ? 0 : h + 1;
            nv = (h == HT - 1) ? ((v == VT - 1) ? 0 : v + 1) : v;
            expVde = (h < HA) && (v < VA);
            expHs  = !((h >= HA + HF) && (h < HA + HF + HS));
            expVs  = !((v >= VA + VF) && (v < VA + VF + VS));
            expFs  = (h == 0) && (v == 0);
            expReq = (nh < HA) && (nv < VA) && (enable || !(nh == 0 && nv == 0));
`ifdef TMDS_GUARD_BAND_EN
            expCd1 = ((v == VT - 1 || v < VA - 1) && h >= HT - 10 && h < HT - 2) ? 2'b01 : 2'b00;
            expVgb = (v == VT - 1 || v < VA - 1) && h >= HT - 2;
`else
            expCd1 = 2'b00;
            expVgb = 1'b0;
`endif
            if (vde !== expVde || cd0 !== {expVs, expHs} || cd1 !== expCd1 || cd2 !== 2'b00 ||
                vgb !== expVgb || frame_start !== expFs) posErr++;
            if (pix_req !== expReq || (expReq && (pix_x !== 12'(nh) || pix_y !== 12'(nv)))) leadErr++;
            if (running !== 1'b1) runErr++;
            if (vde === 1'b1) vdeCount++;
            if (cd0[0] === 1'b0) hsCount++;
            if (cd0[1] === 1'b0) vsCount++;
            if (vgb === 1'b1) vgbCount++;
            if (cd1 === 2'b01) cd1Count++;
            if (frame_start === 1'b1) fsCount++;
            if (v == 0 && cd0[0] === 1'b0 && hsFirst < 0) hsFirst = h;
            @(negedge clk);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        checkOutput("reset_vde", vde, 0);
        checkOutput("reset_pix_req", pix_req, 0);
        checkOutput("reset_running", running, 0);
        checkOutput("reset_frame_start", frame_start, 0);
        checkOutput("reset_cd0", cd0, 2'b11);
        checkOutput("reset_vgb", vgb, 0);

        applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("idle_running", running, 0);
        checkOutput("idle_pix_req", pix_req, 0);
        checkOutput("idle_cd0", cd0, 2'b11);

        // Enable is sampled at the next edge, so the (0,0) fetch is already due
        applyStimulus(1'b1, 1'b0);
        checkOutput("lead_first_req", pix_req, 1);
        checkOutput("lead_first_x", pix_x, 0);
        checkOutput("lead_first_y", pix_y, 0);
        checkOutput("lead_first_vde", vde, 0);
        @(negedge clk);

        runFrame(-1);
        checkOutput("frame_vde_count", vdeCount, EXP_VDE_CNT);
        checkOutput("frame_hsync_count", hsCount, EXP_HS_CNT);
        checkOutput("frame_vsync_count", vsCount, EXP_VS_CNT);
        checkOutput("frame_hsync_first", hsFirst, HA + HF);
        checkOutput("frame_vgb_count", vgbCount, EXP_VGB_CNT);
        checkOutput("frame_cd1_count", cd1Count, EXP_CD1_CNT);
        checkOutput("frame_fs_count", fsCount, 1);
        checkOutput("frame_pos_errors", posErr, 0);
        checkOutput("frame_lead_errors", leadErr, 0);
        checkOutput("frame_running_errors", runErr, 0);

        // Exactly FRAME cycles after the first pulse
        checkOutput("period_frame_start", frame_start, 1);
        checkOutput("period_vde", vde, 1);

        runFrame(2);
        checkOutput("drain_vde_count", vdeCount, EXP_VDE_CNT);
        checkOutput("drain_fs_count", fsCount, 1);
        checkOutput("drain_pos_errors", posErr, 0);
        checkOutput("drain_lead_errors", leadErr, 0);
        checkOutput("drain_running_errors", runErr, 0);
        checkOutput("drain_done_running", running, 0);
        checkOutput("drain_done_vde", vde, 0);
        checkOutput("drain_done_pix_req", pix_req, 0);
        checkOutput("drain_done_frame_start", frame_start, 0);
        checkOutput("drain_done_cd0", cd0, 2'b11);

        // Restart and hit reset in the middle of hsync
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        repeat (20) @(negedge clk);
        checkOutput("rst_pre_cd0", cd0, 2'b10);
        checkOutput("rst_pre_running", running, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_async_cd0", cd0, 2'b11);
        checkOutput("rst_async_vde", vde, 0);
        checkOutput("rst_async_running", running, 0);
        checkOutput("rst_async_frame_start", frame_start, 0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        checkOutput("rst_restart_frame_start", frame_start, 1);
        checkOutput("rst_restart_vde", vde, 1);
        checkOutput("rst_restart_running", running, 1);
        checkOutput("rst_restart_pix_x", pix_x, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
